// File: rtl/ibex_pkg.sv
// Shared types and constants for the fetch realigner.
//
// fetch_entry_t : one buffered fetch word plus its bus-error flag.
// FETCH_DEPTH   : default number of buffered fetch words.
// FETCH_CNT_W   : width of an occupancy counter for FETCH_DEPTH entries (0..FETCH_DEPTH).
// is_compressed : a 16-bit parcel starts a compressed instruction unless its low bits are 2'b11.
package ibex_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ibex_fetch_realigner.sv
// Fetch realigner: buffers 32-bit fetch words and presents one 16- or 32-bit
// instruction per handshake, aligned on a halfword boundary. Instructions that
// straddle two fetch words are stitched together from the head and next entry.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i, clear_addr_i    flush the buffer and redirect the PC (bit0 ignored)
//   in_valid_i/in_ready_o    fetch-word handshake; in_ready_o depends on registered state only
//   in_rdata_i, in_err_i     fetch word (little-endian halfwords) and its bus error
//   out_valid_o/out_ready_i  instruction handshake
//   out_rdata_o              instruction; upper half zero when compressed
//   out_addr_o               PC of the presented instruction
//   out_err_o                instruction touched an errored word
//   out_err_plus2_o          the error is in the second word of a straddling instruction
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high; once valid is raised it stays high with stable
// payload until the transfer happens, except that clear_i withdraws everything.
module ibex_fetch_realigner
    import ibex_pkg::*;
#(
    parameter int unsigned Depth     = FETCH_DEPTH,
    parameter logic [31:0] ResetAddr = 32'h0000_0000,
    parameter bit          ResetAll  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [CntW-1:0] OneCnt   = CntW'(1);
    localparam logic [CntW-1:0] TwoCnt   = CntW'(2);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);

    // Reset PC is word aligned; pc_q holds bits [31:1] since bit0 is always 0.
    localparam logic [31:1] ResetPc = {ResetAddr[31:2], 1'b0};

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:1]     pc_q, pc_d;

    // ------------------------------------------------------------------
    // Output extraction (purely from stored state)
    // ------------------------------------------------------------------
    fetch_entry_t    head;
    fetch_entry_t    nxt;
    logic [PtrW-1:0] nxt_ptr;
    logic [15:0]     head_half;
    logic            head_comp;
    logic            head_valid;
    logic            nxt_valid;

    always_comb begin
        nxt_ptr    = ptr_inc(rd_ptr_q);
        head       = mem_q[rd_ptr_q];
        nxt        = mem_q[nxt_ptr];
        head_valid = (count_q != '0);
        nxt_valid  = (count_q >= TwoCnt);
        head_half  = pc_q[1] ? head.rdata[31:16] : head.rdata[15:0];
        head_comp  = is_compressed(head_half);
    end

    always_comb begin
        out_valid_o     = 1'b0;
        out_rdata_o     = 32'h0;
        out_err_o       = 1'b0;
        out_err_plus2_o = 1'b0;
        if (head_valid) begin
            if (!pc_q[1]) begin
                out_valid_o = 1'b1;
                out_err_o   = head.err;
                out_rdata_o = head_comp ? {16'h0, head_half} : head.rdata;
            end else if (head_comp) begin
                out_valid_o = 1'b1;
                out_err_o   = head.err;
                out_rdata_o = {16'h0, head_half};
            end else if (head.err) begin
                // Faulting first half: report now rather than stall for a
                // second word that may never arrive.
                out_valid_o = 1'b1;
                out_err_o   = 1'b1;
                out_rdata_o = {16'h0, head_half};
            end else if (nxt_valid) begin
                out_valid_o     = 1'b1;
                out_rdata_o     = {nxt.rdata[15:0], head_half};
                out_err_o       = nxt.err;
                out_err_plus2_o = nxt.err;
            end
        end
    end

    assign out_addr_o = {pc_q, 1'b0};
    assign in_ready_o = (count_q < DepthCnt);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic push;
    logic xfer;
    logic pop;

    always_comb begin
        push = in_valid_i & in_ready_o & ~clear_i;
        xfer = out_valid_o & out_ready_i & ~clear_i;
        // The head word is finished once the instruction reaches its upper half.
        pop  = xfer & (pc_q[1] | ~head_comp);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;

        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = clear_addr_i[31:1];
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = nxt_ptr;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + OneCnt;
                2'b01:   count_d = count_q - OneCnt;
                default: count_d = count_q;
            endcase
            if (xfer) begin
                // pc_q counts halfwords: +1 for compressed, +2 otherwise.
                pc_d = pc_q + (head_comp ? 31'd1 : 31'd2);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pc_q     <= ResetPc;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
        end
    end

    // Entry storage: validity comes from count_q, so contents need no reset
    // unless ResetAll asks for deterministic data.
    if (ResetAll) begin : g_mem_reset
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    mem_q[i] <= '0;
                end
            end else if (push) begin
                mem_q[wr_ptr_q] <= '{rdata: in_rdata_i, err: in_err_i};
            end
        end
    end else begin : g_mem_noreset
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{rdata: in_rdata_i, err: in_err_i};
            end
        end
    end

`ifndef SYNTHESIS
    initial begin
        assert (Depth >= 2) else $fatal(1, "ibex_fetch_realigner: Depth must be >= 2");
    end

    a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({out_ready_i, in_valid_i, clear_i}));

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthCnt);

    // Held output must not change until it transfers or is flushed.
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && !out_ready_i && !clear_i) |=>
            (out_valid_o && $stable(out_rdata_o) && $stable(out_addr_o)));
`endif

endmodule

// File: tb/tb_ibex_fetch_realigner.sv
// Directed self-checking bench for ibex_fetch_realigner (Depth=2, ResetAddr=0).
module tb_ibex_fetch_realigner;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic [31:0] clear_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    int checks   = 0;
    int failures = 0;

    ibex_fetch_realigner #(
        .Depth     (2),
        .ResetAddr (32'h0000_0000),
        .ResetAll  (1'b0)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .clear_addr_i    (clear_addr_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_rdata_o     (out_rdata_o),
        .out_addr_o      (out_addr_o),
        .out_err_o       (out_err_o),
        .out_err_plus2_o (out_err_plus2_o)
    );

    // Clock: posedges at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // ------------------------------------------------------------------
    // Driver / check tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] data, input logic err);
        int n;
        in_valid_i = 1'b1;
        in_rdata_i = data;
        in_err_i   = err;
        n = 0;
        while (!in_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("push_ready_timeout", {31'h0, in_ready_o}, 32'h1);
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i      = 1'b1;
        clear_addr_i = addr;
        tick();
        clear_i      = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] rdata, input logic [31:0] addr);
        chk({tag, "_valid"}, {31'h0, out_valid_o}, 32'h1);
        chk({tag, "_rdata"}, out_rdata_o, rdata);
        chk({tag, "_addr"}, out_addr_o, addr);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_ni       = 1'b1;
        clear_i      = 1'b0;
        clear_addr_i = 32'h0;
        in_valid_i   = 1'b0;
        in_rdata_i   = 32'h0;
        in_err_i     = 1'b0;
        out_ready_i  = 1'b0;

        // Reset state
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_rdata", out_rdata_o, 32'h0);
        chk("rst_addr", out_addr_o, 32'h0);
        chk("rst_err", {31'h0, out_err_o}, 32'h0);
        chk("rst_err_plus2", {31'h0, out_err_plus2_o}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready_o}, 32'h1);
        tick();
        rst_ni = 1'b1;
        tick();

        // Aligned stream
        chk("al_empty_valid", {31'h0, out_valid_o}, 32'h0);
        push_word(32'h0041_0513, 1'b0);
        chk_out("al_w0", 32'h0041_0513, 32'h0000_0000);
        chk("al_w0_err", {31'h0, out_err_o}, 32'h0);
        consume();
        chk("al_pop0_valid", {31'h0, out_valid_o}, 32'h0);
        chk("al_pop0_ready", {31'h0, in_ready_o}, 32'h1);
        push_word(32'h4501_4581, 1'b0);
        chk_out("al_c0", 32'h0000_4581, 32'h0000_0004);
        consume();
        chk_out("al_c1", 32'h0000_4501, 32'h0000_0006);
        consume();
        chk("al_pop1_valid", {31'h0, out_valid_o}, 32'h0);
        chk("al_pc8", out_addr_o, 32'h0000_0008);

        // Straddle across two words
        do_clear(32'h0000_0102);
        chk("st_clr_addr", out_addr_o, 32'h0000_0102);
        push_word(32'h0513_0001, 1'b0);
        chk("st_half_valid", {31'h0, out_valid_o}, 32'h0);
        push_word(32'h1111_0041, 1'b0);
        chk_out("st_full", 32'h0041_0513, 32'h0000_0102);
        chk("st_err", {31'h0, out_err_o}, 32'h0);
        consume();
        chk_out("st_tail", 32'h0000_1111, 32'h0000_0106);

        // Error in the second word of a straddle
        do_clear(32'h0000_0002);
        push_word(32'hFFFF_0000, 1'b0);
        chk("es_wait_valid", {31'h0, out_valid_o}, 32'h0);
        push_word(32'h1234_5678, 1'b1);
        chk_out("es_split", 32'h5678_FFFF, 32'h0000_0002);
        chk("es_err", {31'h0, out_err_o}, 32'h1);
        chk("es_err_plus2", {31'h0, out_err_plus2_o}, 32'h1);

        // Error in the first word: reported without waiting for a second word
        do_clear(32'h0000_0002);
        push_word(32'hFFFF_0000, 1'b1);
        chk("ef_valid", {31'h0, out_valid_o}, 32'h1);
        chk("ef_addr", out_addr_o, 32'h0000_0002);
        chk("ef_err", {31'h0, out_err_o}, 32'h1);
        chk("ef_err_plus2", {31'h0, out_err_plus2_o}, 32'h0);

        // Back-pressure with Depth=2
        do_clear(32'h0000_0000);
        push_word(32'h0000_0013, 1'b0);
        chk("bp_ready1", {31'h0, in_ready_o}, 32'h1);
        push_word(32'h0000_0093, 1'b0);
        chk("bp_ready2", {31'h0, in_ready_o}, 32'h0);
        chk_out("bp_a", 32'h0000_0013, 32'h0000_0000);
        in_valid_i = 1'b1;
        in_rdata_i = 32'h0000_0113;
        tick();
        tick();
        chk("bp_hold_ready", {31'h0, in_ready_o}, 32'h0);
        chk_out("bp_a_hold", 32'h0000_0013, 32'h0000_0000);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("bp_free_ready", {31'h0, in_ready_o}, 32'h1);
        chk_out("bp_b", 32'h0000_0093, 32'h0000_0004);
        tick();
        in_valid_i = 1'b0;
        chk("bp_full_again", {31'h0, in_ready_o}, 32'h0);
        chk_out("bp_b_hold", 32'h0000_0093, 32'h0000_0004);
        consume();
        chk_out("bp_c", 32'h0000_0113, 32'h0000_0008);

        // Clear colliding with a push and an output transfer
        clear_i      = 1'b1;
        clear_addr_i = 32'h0000_2003;
        in_valid_i   = 1'b1;
        in_rdata_i   = 32'hDEAD_BEEF;
        out_ready_i  = 1'b1;
        tick();
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("cc_valid", {31'h0, out_valid_o}, 32'h0);
        chk("cc_ready", {31'h0, in_ready_o}, 32'h1);
        chk("cc_addr", out_addr_o, 32'h0000_2002);
        push_word(32'hAAAA_0005, 1'b0);
        chk_out("cc_after", 32'h0000_AAAA, 32'h0000_2002);

        // Asynchronous reset with two entries held
        push_word(32'h0000_0001, 1'b0);
        chk("ar_full", {31'h0, in_ready_o}, 32'h0);
        chk("ar_pre_valid", {31'h0, out_valid_o}, 32'h1);
        #3 rst_ni = 1'b0;
        #1;
        chk("ar_valid", {31'h0, out_valid_o}, 32'h0);
        chk("ar_ready", {31'h0, in_ready_o}, 32'h1);
        chk("ar_addr", out_addr_o, 32'h0000_0000);
        tick();
        rst_ni = 1'b1;
        tick();
        chk("ar_post_valid", {31'h0, out_valid_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
